demux10_router: RTL and testbench
=================================

DEMUX10_ROUTER -- requirements
Module: demux10_router

Interface
REQ-001 Parameter: WIDTH, 16, data width of input and output buses.
REQ-002 clk  input  1  single clock, all state on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  producer has a word on in_data/in_sel.
REQ-005 in_ready  output  1  block accepts the word this cycle.
REQ-006 in_data  input  WIDTH  data word to route.
REQ-007 in_sel  input  10  destination select, priority-coded as in REQ-012.
REQ-008 out_data  output  WIDTH  registered data word, shared by all lanes.
REQ-009 out_valid  output  10  per-lane valid; at most one bit set.
REQ-010 out_ready  input  10  per-lane consumer acceptance.
REQ-011 drop_cnt  output  8  count of words accepted with in_sel == 0 (see Configuration).

Function
REQ-012 The lane SHALL be priority-decoded from in_sel, highest priority first: in_sel[0]->lane1, [1]->lane2, [2]->lane3, [3]->lane4, [4]->lane5, [5]->lane6, [6]->lane7, [7]->lane8, [8]->lane0, [9]->lane9; all-zero->none.
REQ-013 Handshakes: a word transfers on input when in_valid && in_ready; on lane k when out_valid[k] && out_ready[k].
REQ-014 FSM states: IDLE (nothing held) and HOLD (one word held for lane L).
REQ-015 IDLE: in_ready = 1; out_valid = 0; out_data holds its last value.
REQ-016 IDLE, input transfer with a lane decoded: the block SHALL register in_data and L, then go to HOLD. out_valid[L] rises the next cycle, so latency is 1 cycle.
REQ-017 Input transfer with in_sel == 0, in either state: the word SHALL be discarded, the block SHALL stay in or go to IDLE, and drop_cnt SHALL increment.
REQ-018 HOLD: out_valid = one-hot of L. out_data and L SHALL stay stable until the lane transfer.
REQ-019 HOLD: in_ready = out_ready[L] (combinational), giving full throughput of one word per cycle.
REQ-020 HOLD, lane transfer without an input transfer: go to IDLE.
REQ-021 HOLD, lane transfer and input transfer in the same cycle: load the new word and lane, then stay in HOLD, or go to IDLE if in_sel == 0.
REQ-022 out_ready bits for lanes other than L SHALL be ignored.
REQ-023 in_sel SHALL be sampled only on an input transfer; a change in in_sel while a word is held SHALL have no effect.
REQ-024 drop_cnt SHALL saturate at 8'hFF and never wrap.

Reset
REQ-025 When rst_n is low, the block SHALL immediately force state = IDLE, out_valid = 0, out_data = 0, L = 0 and drop_cnt = 0, independent of clk.
REQ-026 A held word SHALL be lost on reset with no lane transfer.
REQ-027 in_ready SHALL read 1 while in reset, because state is IDLE. No transfer occurs until the first rising edge after rst_n deasserts.

Configuration
REQ-028 Macro DEMUX10_DROP_CNT_EN defined: the drop_cnt register is built per REQ-017 and REQ-024.
REQ-029 DEMUX10_DROP_CNT_EN undefined: drop_cnt SHALL be tied to 8'h00 with no counter logic. Words with in_sel == 0 are still accepted and discarded.

Verification
REQ-030 After reset: in_data=16'h1234, in_sel=10'b0000000001, in_valid=1 for one cycle, out_ready=0 -> next cycle out_valid=10'b0000000010 and out_data=16'h1234, both held stable for 5 cycles while in_ready=0.
REQ-031 Priority decode: in_sel=10'b1100000000 -> out_valid=10'b0000000001 (lane0); in_sel=10'b1000000000 -> out_valid=10'b1000000000 (lane9).
REQ-032 Streaming: out_ready=all 1s, in_valid held 1, data 16'h0001..16'h0008 to lanes 1..8 -> one lane transfer per cycle, in_ready stays 1, no word lost or duplicated.
REQ-033 Drop: 300 consecutive transfers with in_sel=0 -> out_valid stays 0 and drop_cnt=8'hFF. With macro undefined -> drop_cnt=8'h00.
REQ-034 Reset mid-HOLD: assert rst_n=0 asynchronously between edges while out_valid[3]=1 -> out_valid=0 and out_data=16'h0000 before the next edge, and in_ready=1.

Source files
------------

// File: rtl/demux10_router_if.sv
// Handshake bundle for demux10_router: one producer port, ten consumer lanes sharing a data bus.
interface demux10_router_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [9:0]       in_sel;
  logic [WIDTH-1:0] out_data;
  logic [9:0]       out_valid;
  logic [9:0]       out_ready;
  logic [7:0]       drop_cnt;

  modport master (
    output in_valid, in_data, in_sel, out_ready,
    input  in_ready, out_data, out_valid, drop_cnt
  );

  modport slave (
    input  in_valid, in_data, in_sel, out_ready,
    output in_ready, out_data, out_valid, drop_cnt
  );
endinterface

// File: rtl/demux10_router.sv
// 1-to-10 priority-select demultiplexer with a single holding register and full-throughput handshake.
// Optional drop counter for words with no destination is built when DEMUX10_DROP_CNT_EN is defined.
module demux10_router #(
  parameter int WIDTH = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  demux10_router_if.slave   bus
);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [3:0]       lane_q, lane_d;

  logic [3:0]       sel_lane;
  logic             sel_hit;
  logic             in_xfer;
  logic             lane_xfer;

  // Loop runs high-to-low so the lowest set in_sel bit wins.
  always_comb begin
    sel_hit  = |bus.in_sel;
    sel_lane = 4'd0;
    for (int i = 9; i >= 0; i--) begin
      if (bus.in_sel[i]) begin
        if (i < 8)       sel_lane = 4'(i + 1);
        else if (i == 8) sel_lane = 4'd0;
        else             sel_lane = 4'd9;
      end
    end
  end

  always_comb begin
    bus.in_ready = 1'b1;
    lane_xfer    = 1'b0;
    if (state_q == HOLD) begin
      bus.in_ready = bus.out_ready[lane_q];
      lane_xfer    = bus.out_ready[lane_q];
    end
    in_xfer = bus.in_valid && bus.in_ready;
  end

  // In HOLD an input transfer implies the lane transfer, so the new word simply replaces the old.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    lane_d  = lane_q;
    if (in_xfer) begin
      if (sel_hit) begin
        state_d = HOLD;
        data_d  = bus.in_data;
        lane_d  = sel_lane;
      end else begin
        state_d = IDLE;
      end
    end else if (lane_xfer) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      lane_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      lane_q  <= lane_d;
    end
  end

  assign bus.out_data = data_q;

  generate
    for (genvar gi = 0; gi < 10; gi++) begin : g_lane_valid
      assign bus.out_valid[gi] = (state_q == HOLD) && (lane_q == 4'(gi));
    end
  endgenerate

`ifdef DEMUX10_DROP_CNT_EN
  logic [7:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (in_xfer && !sel_hit && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_d = drop_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt_q <= 8'h00;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign bus.drop_cnt = drop_cnt_q;
`else
  assign bus.drop_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_demux10_router.sv
// Scoreboard bench for demux10_router: driver pushes expected lane/data, negedge monitor pops on lane transfers.
module tb_demux10_router;

  typedef struct {
    int          lane;
    logic [15:0] data;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;
  int   xfer_cnt;
  int   w;
  exp_t sb[$];

  demux10_router_if #(.WIDTH(16)) bus ();

  demux10_router #(.WIDTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef DEMUX10_DROP_CNT_EN
  localparam logic [7:0] DROP5   = 8'd5;
  localparam logic [7:0] DROPMAX = 8'hFF;
`else
  localparam logic [7:0] DROP5   = 8'h00;
  localparam logic [7:0] DROPMAX = 8'h00;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Presents one word and waits (bounded) for acceptance; exp_lane < 0 means the word is dropped.
  task automatic send(input logic [15:0] d, input logic [9:0] s, input int exp_lane, output int waits);
    exp_t e;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_sel   = s;
    waits = 0;
    @(negedge clk);
    while (!bus.in_ready && waits < 50) begin
      waits++;
      @(negedge clk);
    end
    if (!bus.in_ready) chk("send_timeout", 32'(waits), 32'd0);
    if (exp_lane >= 0) begin
      e.lane = exp_lane;
      e.data = d;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    chk("onehot", 32'($onehot0(bus.out_valid)), 32'd1);
    if ((bus.out_valid & bus.out_ready) != 10'd0) begin
      xfer_cnt++;
      if (sb.size() == 0) begin
        chk("unexpected_xfer", {22'd0, bus.out_valid}, 32'd0);
      end else begin
        e = sb.pop_front();
        $display("xfer lane=%0d data=%h (exp lane=%0d data=%h)", $clog2(bus.out_valid), bus.out_data, e.lane, e.data);
        chk("lane", {22'd0, bus.out_valid}, 32'(10'd1 << e.lane));
        chk("data", {16'd0, bus.out_data}, {16'd0, e.data});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int start_x;
    n_chk = 0; n_fail = 0; xfer_cnt = 0;
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.in_sel = '0; bus.out_ready = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", {22'd0, bus.out_valid}, 32'd0);
    chk("rst_out_data", {16'd0, bus.out_data}, 32'd0);
    chk("rst_drop_cnt", {24'd0, bus.drop_cnt}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single word to lane1 held with no consumer.
    send(16'h1234, 10'b0000000001, 1, w);
    bus.in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_valid", {22'd0, bus.out_valid}, 32'h002);
      chk("hold_data", {16'd0, bus.out_data}, 32'h1234);
      chk("hold_in_ready", 32'(bus.in_ready), 32'd0);
    end
    @(posedge clk); #1;
    bus.out_ready = '1;
    repeat (2) @(posedge clk); #1;

    // Priority decode.
    send(16'hA000, 10'b1100000000, 0, w);
    send(16'hA009, 10'b1000000000, 9, w);
    send(16'hA001, 10'b1111111111, 1, w);
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk); #1;

    // Back-to-back streaming to lanes 1..8.
    start_x = xfer_cnt;
    for (int k = 1; k <= 8; k++) begin
      send(16'(k), 10'd1 << (k - 1), k, w);
      chk("stream_stall", 32'(w), 32'd0);
    end
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk); #1;
    chk("stream_count", 32'(xfer_cnt - start_x), 32'd8);
    chk("stream_sb_empty", 32'(sb.size()), 32'd0);

    // Other lanes' ready and in_sel changes must not release the held word.
    bus.out_ready = 10'h3F7;
    send(16'hBEEF, 10'b0000000100, 3, w);
    bus.in_valid = 1'b0;
    bus.in_sel = 10'b1000000000;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("ign_valid", {22'd0, bus.out_valid}, 32'h008);
      chk("ign_in_ready", 32'(bus.in_ready), 32'd0);
      chk("ign_data", {16'd0, bus.out_data}, 32'hBEEF);
    end
    @(posedge clk); #1;
    bus.out_ready = '1;
    repeat (2) @(posedge clk); #1;

    // Drops: counter value after 5 and after 300.
    for (int i = 0; i < 300; i++) begin
      send(16'(i), 10'd0, -1, w);
      if (i == 4) begin
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("drop_cnt_5", {24'd0, bus.drop_cnt}, {24'd0, DROP5});
        @(posedge clk); #1;
      end
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("drop_cnt_sat", {24'd0, bus.drop_cnt}, {24'd0, DROPMAX});
    chk("drop_out_valid", {22'd0, bus.out_valid}, 32'd0);
    @(posedge clk); #1;

    // Drop while holding: lane transfer plus discard returns to IDLE.
    bus.out_ready = '0;
    send(16'h5555, 10'b0000010000, 5, w);
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    bus.out_ready = '1;
    send(16'hAAAA, 10'd0, -1, w);
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("hold_drop_idle", {22'd0, bus.out_valid}, 32'd0);
    chk("hold_drop_cnt", {24'd0, bus.drop_cnt}, {24'd0, DROPMAX});
    @(posedge clk); #1;

    // Asynchronous reset while lane3 is held.
    bus.out_ready = '0;
    send(16'hC0DE, 10'b0000000100, 3, w);
    bus.in_valid = 1'b0;
    chk("pre_rst_valid", {22'd0, bus.out_valid}, 32'h008);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", {22'd0, bus.out_valid}, 32'd0);
    chk("async_rst_data", {16'd0, bus.out_data}, 32'd0);
    chk("async_rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("async_rst_drop", {24'd0, bus.drop_cnt}, 32'd0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = '1;
    send(16'h7777, 10'b0010000000, 8, w);
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk); #1;
    chk("final_sb_empty", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
